// File: rtl/axis_gen_pkg.sv
// Shared encodings for the AXI4-Stream frame generator.
// Holds fill-mode codes, FSM state type and a counter-width helper.
`timescale 1ns/1ps
package axis_gen_pkg;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_INC   = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_LINE  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter width for a modulo-n counter; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_gen_pattern.sv
// Combinational next-tdata function of mode, fill, beat count, x and y.
// Ports: mode, fill, n (beat in frame), x0 (x lsb), y (line) -> data.
`timescale 1ns/1ps
module axis_gen_pattern
    import axis_gen_pkg::*;
#(
    parameter int DW = 32,
    parameter int YW = 1
) (
    input  logic [1:0]    mode,
    input  logic [DW-1:0] fill,
    input  logic [DW-1:0] n,
    input  logic          x0,
    input  logic [YW-1:0] y,
    output logic [DW-1:0] data
);

    always_comb begin
        data = fill;
        unique case (1'b1)
            (mode == MODE_INC):   data = fill + n;
            (mode == MODE_CHECK): data = (x0 ^ y[0]) ? ~fill : fill;
            (mode == MODE_LINE):  data = DW'(y);
            default:              data = fill;
        endcase
    end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI4-Stream test-pattern source: LINES x LINE_LENGTH beats per frame.
// Ports: clk, rst, enable, mode, fill_value in; M_AXIS tdata/tvalid/
// tlast/tuser out, tready in; frame_done pulse and busy status out.
`timescale 1ns/1ps
module axis_frame_gen
    import axis_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_LENGTH = 32,
    parameter int LINES       = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  tlast,
    output logic                  tuser,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int XW = cnt_width(LINE_LENGTH);
    localparam int YW = cnt_width(LINES);
    localparam logic [XW-1:0] X_LAST = XW'(LINE_LENGTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LINES - 1);

    state_e                state;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [DATA_WIDTH-1:0] n;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] fill_q;

    logic                  xfer;
    logic                  eol;
    logic                  eof;
    logic                  latch;
    logic [XW-1:0]         nx;
    logic [YW-1:0]         ny;
    logic [DATA_WIDTH-1:0] nn;
    logic [1:0]            pat_mode;
    logic [DATA_WIDTH-1:0] pat_fill;
    logic [DATA_WIDTH-1:0] pat_data;
    logic                  nxt_last;
    logic                  nxt_user;

    assign xfer = tvalid & tready;
    assign eol  = (x == X_LAST);
    assign eof  = eol && (y == Y_LAST);

    // New mode/fill are taken at start-up and at a frame boundary only.
    assign latch = (state == ST_IDLE) ? enable
                                      : (xfer && eof && enable);

    // Position of the beat that follows the current one.
    always_comb begin
        nx = x + 1'b1;
        ny = y;
        nn = n + 1'b1;
        if (state == ST_IDLE || eof) begin
            nx = '0;
            ny = '0;
            nn = '0;
        end else if (eol) begin
            nx = '0;
            ny = y + 1'b1;
        end
    end

    assign pat_mode = latch ? mode : mode_q;
    assign pat_fill = latch ? fill_value : fill_q;
    assign nxt_last = (nx == X_LAST);
    assign nxt_user = (nx == '0) && (ny == '0);

    axis_gen_pattern #(
        .DW (DATA_WIDTH),
        .YW (YW)
    ) u_pattern (
        .mode (pat_mode),
        .fill (pat_fill),
        .n    (nn),
        .x0   (nx[0]),
        .y    (ny),
        .data (pat_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            n          <= '0;
            mode_q     <= MODE_CONST;
            fill_q     <= '0;
            tdata      <= '0;
            tvalid     <= 1'b0;
            tlast      <= 1'b0;
            tuser      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        mode_q <= mode;
                        fill_q <= fill_value;
                        x      <= nx;
                        y      <= ny;
                        n      <= nn;
                        tdata  <= pat_data;
                        tlast  <= nxt_last;
                        tuser  <= nxt_user;
                        tvalid <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        x <= nx;
                        y <= ny;
                        n <= nn;
                        if (eof) begin
                            frame_done <= 1'b1;
                        end
                        if (eof && !enable) begin
                            tvalid <= 1'b0;
                            tlast  <= 1'b0;
                            tuser  <= 1'b0;
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            if (latch) begin
                                mode_q <= mode;
                                fill_q <= fill_value;
                            end
                            tdata <= pat_data;
                            tlast <= nxt_last;
                            tuser <= nxt_user;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen (LINE_LENGTH=4, LINES=2).
// Directed frames push expected beats; a monitor pops on each transfer.
`timescale 1ns/1ps
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [31:0] fill_value;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    logic        frame_done;
    logic        busy;

    always #5 clk = ~clk;

    axis_frame_gen #(
        .DATA_WIDTH  (32),
        .LINE_LENGTH (4),
        .LINES       (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .fill_value (fill_value),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (tready),
        .tlast      (tlast),
        .tuser      (tuser),
        .frame_done (frame_done),
        .busy       (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic        eof;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] vec [8];
    logic        bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Queue one full frame from vec; line/frame flags follow beat index.
    task automatic push_vec();
        beat_t nb;
        for (int i = 0; i < 8; i++) begin
            nb.data = vec[i];
            nb.last = (i % 4 == 3);
            nb.user = (i == 0);
            nb.eof  = (i == 7);
            exp_q.push_back(nb);
        end
    endtask

    task automatic start(input logic [1:0] m, input logic [31:0] f,
                         input bit keep);
        @(negedge clk);
        mode       = m;
        fill_value = f;
        enable     = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) enable = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        bit got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("frame_done_seen", 32'(got), 32'd1);
    endtask

    // Monitor: transfers, hold-during-stall and frame_done timing.
    beat_t       mb;
    logic        stall_q = 1'b0;
    logic        fd_exp  = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic        held_user;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
            fd_exp  = 1'b0;
        end else begin
            if (fd_exp || frame_done)
                chk("frame_done", 32'(frame_done), 32'(fd_exp));
            fd_exp = 1'b0;
            if (stall_q) begin
                chk("hold_valid", 32'(tvalid), 32'd1);
                chk("hold_data", tdata, held_data);
                chk("hold_flags", {30'd0, tlast, tuser},
                    {30'd0, held_last, held_user});
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none",
                             tdata);
                end else begin
                    mb = exp_q.pop_front();
                    chk("tdata", tdata, mb.data);
                    chk("tlast", 32'(tlast), 32'(mb.last));
                    chk("tuser", 32'(tuser), 32'(mb.user));
                    fd_exp = mb.eof;
                end
            end
            stall_q   = tvalid && !tready;
            held_data = tdata;
            held_last = tlast;
            held_user = tuser;
        end
    end

    initial begin
        bit got;
        beat_t nb;
        rst        = 1'b1;
        enable     = 1'b0;
        mode       = 2'd0;
        fill_value = 32'd0;
        tready     = 1'b1;
        #12;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tuser", 32'(tuser), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Constant fill
        vec = '{8{32'h00FF00FF}};
        push_vec();
        start(2'd0, 32'h00FF00FF, 1'b0);
        wait_fd(40);
        @(negedge clk);
        chk("t1_idle_valid", 32'(tvalid), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Incrementing under backpressure
        vec = '{32'd100, 32'd101, 32'd102, 32'd103,
                32'd104, 32'd105, 32'd106, 32'd107};
        push_vec();
        start(2'd1, 32'd100, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk);
            #1 tready = bp_pat[c % 7];
            @(negedge clk);
            if (frame_done) got = 1'b1;
        end
        chk("t2_done", 32'(got), 32'd1);
        tready = 1'b1;

        // Back-to-back frames, mode change mid-frame
        vec = '{32'h10, 32'h11, 32'h12, 32'h13,
                32'h14, 32'h15, 32'h16, 32'h17};
        push_vec();
        vec = '{32'd0, 32'd0, 32'd0, 32'd0,
                32'd1, 32'd1, 32'd1, 32'd1};
        push_vec();
        start(2'd1, 32'h10, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mode       = 2'd3;
        fill_value = 32'hDEAD0000;
        wait_fd(40);
        chk("t3_no_bubble", 32'(tvalid), 32'd1);
        chk("t3_sof", 32'(tuser), 32'd1);
        enable = 1'b0;
        wait_fd(40);
        @(negedge clk);
        chk("t3_idle_valid", 32'(tvalid), 32'd0);

        // Checkerboard
        vec = '{32'h0000FFFF, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000,
                32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000, 32'h0000FFFF};
        push_vec();
        start(2'd2, 32'h0000FFFF, 1'b0);
        wait_fd(40);

        // Enable dropped at beat 3: frame completes, then idle
        vec = '{8{32'h5A5A5A5A}};
        push_vec();
        start(2'd0, 32'h5A5A5A5A, 1'b1);
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        wait_fd(40);
        chk("t5_fd_valid", 32'(tvalid), 32'd0);
        chk("t5_fd_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t5_after_valid", 32'(tvalid), 32'd0);
        chk("t5_after_busy", 32'(busy), 32'd0);

        // Async reset while beat 5 is stalled
        for (int i = 0; i < 5; i++) begin
            nb.data = 32'(i);
            nb.last = (i == 3);
            nb.user = (i == 0);
            nb.eof  = 1'b0;
            exp_q.push_back(nb);
        end
        start(2'd1, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1 tready = 1'b0;
        @(negedge clk);
        chk("t6_stall_data", tdata, 32'd5);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(tvalid), 32'd0);
        chk("t6_rst_tlast", 32'(tlast), 32'd0);
        chk("t6_rst_tuser", 32'(tuser), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_tdata", tdata, 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_hold_valid", 32'(tvalid), 32'd0);
        rst    = 1'b0;
        tready = 1'b1;
        vec = '{32'h200, 32'h201, 32'h202, 32'h203,
                32'h204, 32'h205, 32'h206, 32'h207};
        push_vec();
        start(2'd1, 32'h200, 1'b0);
        wait_fd(40);
        repeat (2) @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
